// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 sensor stand-in: answers a qualified trigger pulse with an echo whose
// width encodes the programmed distance, then holds off before re-arming.
module hcsr04_echo_responder #(
    parameter int CNT_W        = 21,
    parameter int TRIG_MIN     = 500,
    parameter int BURST_CYCLES = 10000,
    parameter int CYC_PER_CM   = 2941,
    parameter int DIST_MIN     = 2,
    parameter int DIST_MAX     = 400,
    parameter int ECHO_MAX     = 1900000,
    parameter int HOLDOFF      = 500000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       trigger,
    input  logic [8:0] distance,
    output logic       echo,
    output logic       busy,
    output logic       trig_err,
    output logic       echo_done
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TRIG_HI = 3'd1;
    localparam logic [2:0] ST_BURST   = 3'd2;
    localparam logic [2:0] ST_ECHO    = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    localparam logic [CNT_W-1:0] TRIG_MIN_C   = CNT_W'(TRIG_MIN);
    localparam logic [CNT_W-1:0] BURST_LAST_C = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_PER_CM_C = CNT_W'(CYC_PER_CM);
    localparam logic [CNT_W-1:0] ECHO_MAX_C   = CNT_W'(ECHO_MAX);
    localparam logic [CNT_W-1:0] HOLDOFF_C    = CNT_W'(HOLDOFF);
    localparam logic [8:0]       DIST_MIN_C   = 9'(DIST_MIN);
    localparam logic [8:0]       DIST_MAX_C   = 9'(DIST_MAX);

    logic             trig_m;
    logic             trig_s;
    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nx;
    logic [8:0]       dist_q;
    logic [8:0]       dist_nx;
    logic [CNT_W-1:0] target;
    logic             echo_nx;
    logic             err_nx;
    logic             done_nx;
    logic             busy_nx;

    // Out-of-range distances (including 0) report the sensor's timeout width.
    always_comb begin
        if (dist_q >= DIST_MIN_C && dist_q <= DIST_MAX_C)
            target = CNT_W'(dist_q) * CYC_PER_CM_C;
        else
            target = ECHO_MAX_C;
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        dist_nx  = dist_q;
        echo_nx  = echo;
        err_nx   = 1'b0;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig_s) begin
                    state_nx = ST_TRIG_HI;
                    count_nx = CNT_W'(1);
                end
            end
            ST_TRIG_HI: begin
                if (trig_s) begin
                    if (count < TRIG_MIN_C)
                        count_nx = count + CNT_W'(1);
                end else if (count >= TRIG_MIN_C) begin
                    dist_nx  = distance;
                    state_nx = ST_BURST;
                    count_nx = '0;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                    count_nx = '0;
                end
            end
            ST_BURST: begin
                if (count == BURST_LAST_C) begin
                    state_nx = ST_ECHO;
                    echo_nx  = 1'b1;
                    count_nx = CNT_W'(1);
                end else begin
                    count_nx = count + CNT_W'(1);
                end
            end
            ST_ECHO: begin
                if (count == target) begin
                    state_nx = ST_HOLDOFF;
                    echo_nx  = 1'b0;
                    done_nx  = 1'b1;
                    count_nx = CNT_W'(1);
                end else begin
                    count_nx = count + CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (count == HOLDOFF_C) begin
                    state_nx = ST_IDLE;
                    count_nx = '0;
                end else begin
                    count_nx = count + CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                count_nx = '0;
                echo_nx  = 1'b0;
            end
        endcase
        busy_nx = (state_nx == ST_BURST) || (state_nx == ST_ECHO) ||
                  (state_nx == ST_HOLDOFF);
    end

    // Outputs are registered from next-state values so they track the state exactly.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            trig_m    <= 1'b0;
            trig_s    <= 1'b0;
            state     <= ST_IDLE;
            count     <= '0;
            dist_q    <= '0;
            echo      <= 1'b0;
            busy      <= 1'b0;
            trig_err  <= 1'b0;
            echo_done <= 1'b0;
        end else begin
            trig_m    <= trigger;
            trig_s    <= trig_m;
            state     <= state_nx;
            count     <= count_nx;
            dist_q    <= dist_nx;
            echo      <= echo_nx;
            busy      <= busy_nx;
            trig_err  <= err_nx;
            echo_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_hcsr04_echo_responder.sv
// Scoreboard bench for hcsr04_echo_responder with shortened timing parameters
// so full measurement cycles stay short.
module tb_hcsr04_echo_responder;

    localparam int P_CNT_W        = 16;
    localparam int P_TRIG_MIN     = 20;
    localparam int P_BURST_CYCLES = 50;
    localparam int P_CYC_PER_CM   = 5;
    localparam int P_DIST_MIN     = 2;
    localparam int P_DIST_MAX     = 400;
    localparam int P_ECHO_MAX     = 2500;
    localparam int P_HOLDOFF      = 150;

    logic       clk_in   = 1'b0;
    logic       rst      = 1'b1;
    logic       trigger  = 1'b0;
    logic [8:0] distance = '0;
    logic       echo;
    logic       busy;
    logic       trig_err;
    logic       echo_done;

    hcsr04_echo_responder #(
        .CNT_W       (P_CNT_W),
        .TRIG_MIN    (P_TRIG_MIN),
        .BURST_CYCLES(P_BURST_CYCLES),
        .CYC_PER_CM  (P_CYC_PER_CM),
        .DIST_MIN    (P_DIST_MIN),
        .DIST_MAX    (P_DIST_MAX),
        .ECHO_MAX    (P_ECHO_MAX),
        .HOLDOFF     (P_HOLDOFF)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .trigger  (trigger),
        .distance (distance),
        .echo     (echo),
        .busy     (busy),
        .trig_err (trig_err),
        .echo_done(echo_done)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int t0;
        int width;
        bit noDone;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   idle_at    = 0;
    bit   last_echo  = 1'b0;
    int   last_rise  = 0;
    int   last_width = 0;
    bit   prev_echo  = 1'b0;
    int   rise_cyc   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flagEvent(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: event seen at cycle %0d, none expected", name, cyc);
    endtask

    function automatic int refWidth(input int d);
        return (d >= P_DIST_MIN && d <= P_DIST_MAX) ? d * P_CYC_PER_CM : P_ECHO_MAX;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) tick();
    endtask

    task automatic waitIdle();
        if (last_echo && cyc < idle_at - 1) begin
            waitUntil(idle_at - 1);
            checkOutput("busyLastHoldoff", busy, 1);
            tick();
            checkOutput("busyAfterHoldoff", busy, 0);
        end else begin
            waitUntil(idle_at);
        end
        last_echo = 1'b0;
    endtask

    // Returns f: the first clock edge that samples the trigger low.
    task automatic pulse(input int n, output int f);
        tick();
        trigger = 1'b1;
        repeat (n) tick();
        trigger = 1'b0;
        f = cyc + 1;
    endtask

    task automatic applyStimulus(input int n, input int d);
        int f;
        waitIdle();
        distance = 9'(d);
        pulse(n, f);
        if (n >= P_TRIG_MIN) begin
            last_rise  = f + 2 + P_BURST_CYCLES;
            last_width = refWidth(d);
            expQ.push_back('{kind: 1, t0: last_rise, width: last_width, noDone: 1'b0});
            idle_at   = last_rise + last_width + P_HOLDOFF;
            last_echo = 1'b1;
        end else begin
            expQ.push_back('{kind: 0, t0: f + 2, width: 0, noDone: 1'b0});
            idle_at   = f + 2;
            last_echo = 1'b0;
        end
        waitUntil(f + 2);
        distance = 9'($urandom_range(0, 511));
    endtask

    task automatic issueIgnored(input int start_at, input int n);
        int f;
        waitUntil(start_at);
        pulse(n, f);
    endtask

    // Monitor: consumes scoreboard entries as the DUT presents echo edges and trig_err.
    always @(negedge clk_in) begin
        exp_t e;
        if (echo && !prev_echo) begin
            rise_cyc = cyc;
            if (expQ.size() == 0 || expQ[0].kind != 1)
                flagEvent("unexpectedEcho");
            else
                checkOutput("echoRiseCycle", cyc, expQ[0].t0);
        end
        if (!echo && prev_echo) begin
            if (expQ.size() > 0 && expQ[0].kind == 1) begin
                e = expQ.pop_front();
                checkOutput("echoWidth", cyc - rise_cyc, e.width);
                checkOutput("echoDoneAtFall", echo_done, e.noDone ? 0 : 1);
            end
        end else if (echo_done) begin
            flagEvent("strayEchoDone");
        end
        if (trig_err) begin
            if (expQ.size() > 0 && expQ[0].kind == 0) begin
                e = expQ.pop_front();
                checkOutput("trigErrCycle", cyc, e.t0);
            end else begin
                flagEvent("unexpectedTrigErr");
            end
        end
        prev_echo = echo;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run did not complete, queue depth %0d", expQ.size());
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        int n;
        int d;
        int sel;
        rst = 1'b1;
        repeat (5) tick();
        checkOutput("resetEcho", echo, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetTrigErr", trig_err, 0);
        checkOutput("resetEchoDone", echo_done, 0);
        rst = 1'b0;
        idle_at = cyc;

        // Nominal, then short/boundary trigger widths
        applyStimulus(40, 10);
        applyStimulus(5, 10);
        applyStimulus(P_TRIG_MIN - 1, 50);
        applyStimulus(P_TRIG_MIN, 50);

        // Range boundaries
        applyStimulus(30, 0);
        applyStimulus(30, 450);
        applyStimulus(30, 400);
        applyStimulus(30, 2);
        applyStimulus(30, 1);
        applyStimulus(30, 401);

        // Triggers and distance changes while busy must not disturb the echo
        applyStimulus(30, 100);
        issueIgnored(last_rise + 50, 30);
        waitUntil(last_rise + 100);
        distance = 9'd7;
        issueIgnored(last_rise + last_width + 20, 30);

        // Reset in the middle of an echo truncates it without echo_done
        applyStimulus(30, 300);
        waitUntil(last_rise + 100);
        if (expQ.size() > 0) begin
            expQ[0].width  = cyc + 1 - last_rise;
            expQ[0].noDone = 1'b1;
        end
        rst = 1'b1;
        tick();
        checkOutput("midResetEcho", echo, 0);
        checkOutput("midResetBusy", busy, 0);
        repeat (2) tick();
        rst = 1'b0;
        idle_at   = cyc;
        last_echo = 1'b0;
        applyStimulus(30, 60);

        // Long stuck trigger
        applyStimulus(2000, 123);

        for (int i = 0; i < 10; i++) begin
            n   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, P_TRIG_MIN - 1)
                                              : $urandom_range(P_TRIG_MIN, 80);
            sel = $urandom_range(0, 9);
            case (sel)
                0:       d = 0;
                1:       d = 1;
                2:       d = 2;
                3:       d = 400;
                4:       d = 401;
                default: d = $urandom_range(0, 511);
            endcase
            applyStimulus(n, d);
        end

        waitIdle();
        repeat (5) tick();
        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hcsr04_echo_responder.md
Name: hcsr04_echo_responder

Overview:
- Sensor-side model of the HC-SR04 trigger/echo protocol. It answers the trigger pulse from our distance controller with an echo pulse whose width encodes a programmed distance.
- Used as a hardware-in-loop stand-in on the FPGA board and as the bench responder for the controller. Lets the controller's LED bands be exercised without a physical sensor.
- Timing defaults assume the 50 MHz board clock.

Parameters:
- CNT_W, 21, width of the shared duration counter (must hold ECHO_MAX and HOLDOFF).
- TRIG_MIN, 500, minimum synchronized trigger-high cycles for a valid request (10 us).
- BURST_CYCLES, 10000, dead time between trigger fall and echo rise (emulated 40 kHz burst, 200 us).
- CYC_PER_CM, 2941, echo-high cycles per centimetre (58.8 us/cm).
- DIST_MIN, 2, smallest in-range distance in cm.
- DIST_MAX, 400, largest in-range distance in cm.
- ECHO_MAX, 1900000, echo width for an out-of-range target (38 ms timeout).
- HOLDOFF, 500000, recovery cycles after echo fall before a new trigger is accepted (10 ms).

Ports:
- clk_in  input  1  system clock, 50 MHz.
- rst  input  1  synchronous reset, active-high.
- trigger  input  1  asynchronous trigger from the controller.
- distance  input  9  target distance in cm, sampled once per measurement.
- echo  output  1  echo pulse back to the controller.
- busy  output  1  high in BURST, ECHO and HOLDOFF.
- trig_err  output  1  one-cycle pulse when a trigger is rejected as too short.
- echo_done  output  1  one-cycle pulse on the cycle echo falls.

Behaviour:
- trigger passes through a 2-flop synchronizer (trig_s). All timing below refers to trig_s.
- Reset (rst=1 at a clk_in edge):
  - state=IDLE, counter=0, synchronizer flops=0.
  - echo=0, busy=0, trig_err=0, echo_done=0.
  - Reset mid-echo drops echo on that edge; no echo_done is issued.
- IDLE: trig_s=1 -> TRIG_HI, counter=1.
- TRIG_HI:
  - While trig_s=1, counter increments, saturating at TRIG_MIN.
  - On trig_s=0 with counter>=TRIG_MIN: latch distance into dist_q, go to BURST, counter=0.
  - On trig_s=0 with counter<TRIG_MIN: pulse trig_err for 1 cycle, return to IDLE.
  - Trigger held high indefinitely: stay in TRIG_HI, no echo.
- BURST: count BURST_CYCLES cycles, then go to ECHO with echo=1.
- Echo length:
  - If DIST_MIN<=dist_q<=DIST_MAX: target = dist_q*CYC_PER_CM, computed at full CNT_W width with no truncation.
  - Otherwise (including 0 and >400): target = ECHO_MAX.
- ECHO: echo is high for exactly target cycles. Then echo=0, echo_done pulses on that same cycle, and the block enters HOLDOFF.
- HOLDOFF: count HOLDOFF cycles, then return to IDLE.
- Triggers arriving in BURST, ECHO or HOLDOFF are ignored: no state change, no trig_err.
  - A trigger still high when HOLDOFF ends is taken as a fresh rising request from IDLE. Its counted width starts at that point.
- Latency: edges from the first clk_in edge that samples raw trigger=0 (end of a valid pulse):
  - echo rises 2+BURST_CYCLES edges later.
  - echo falls target edges after its rise.
- The distance input may change at any time. Only the value latched at the trigger fall affects the current echo.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Nominal: rst 5 cycles, trigger high 1000 cycles, distance=10 -> echo rises 10002 cycles after trigger fall sample; echo high exactly 29410 cycles; echo_done single pulse at the fall; busy high through HOLDOFF, then low.
- Short trigger: trigger high 100 cycles -> trig_err one pulse, echo stays 0, busy stays 0; a following 600-cycle trigger yields a normal echo.
- Out of range: distance=0, then distance=450, each with a 600-cycle trigger -> echo width 1900000 both times; distance=400 -> width 1176400; distance=2 -> width 5882.
- Busy rejection: a second 600-cycle trigger issued mid-ECHO and again mid-HOLDOFF -> echo width unchanged, no trig_err, no extra echo. Changing distance mid-ECHO has no effect on the current width.
- Reset mid-operation: assert rst 3 cycles at echo cycle 5000 -> echo=0 and busy=0 on the first reset edge, no echo_done; the next valid trigger gives a full, correct echo.
- Stuck trigger: trigger held high 20000 cycles then released -> exactly one echo, latency and width per distance.
